// File: rtl/mem_pkg.sv
// Shared types and limits for the data memory responder and its storage array.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

    localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/data_mem_responder_if.sv
// Datapath load/store bus between a requester (master) and the memory responder (slave).
interface data_mem_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:2] Address;
    logic [NBITS-1:0] WriteData;
    logic             MemRead;
    logic             MemWrite;
    logic [NBITS-1:0] ReadData;
    logic             Ready;
    logic             Error;
    logic             Busy;

    modport master (
        output Address, WriteData, MemRead, MemWrite,
        input  ReadData, Ready, Error, Busy
    );

    modport slave (
        input  Address, WriteData, MemRead, MemWrite,
        output ReadData, Ready, Error, Busy
    );
endinterface

// File: rtl/data_mem_array.sv
// Word storage with synchronous write, registered read and synchronous clear.
// The caller only asserts we/re for in-range addresses.
module data_mem_array #(
    parameter int NBITS  = 8,
    parameter int NWORDS = 64,
    parameter int AW     = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [NBITS-1:0] wdata,
    output logic [NBITS-1:0] rdata
);
    logic [NBITS-1:0] mem [NWORDS];
    logic [NBITS-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            if (re) begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency word memory on the datapath load/store bus: capture one request,
// wait LATENCY edges, perform the access and raise Ready for one cycle.
module data_mem_responder #(
    parameter int NBITS   = 8,
    parameter int NWORDS  = 2**(NBITS-2),
    parameter int LATENCY = 2
) (
    input logic       clock,
    input logic       reset,
    data_mem_if.slave bus
);
    import mem_pkg::*;

    localparam int AW  = NBITS - 2;
    // Out-of-range latency values saturate to the supported window.
    localparam int LAT = (LATENCY < 1) ? 1 : ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);
    localparam int CW  = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
    localparam logic [AW:0]   NWORDS_W = (AW + 1)'(NWORDS);

    mem_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [NBITS-1:0] wdata_q, wdata_d;
    logic             write_q, write_d;
    logic             err_q, err_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ready_q, busy_q;

    logic             in_range;
    logic             arr_we, arr_re;
    logic [NBITS-1:0] arr_rdata;

    assign in_range = ({1'b0, addr_q} < NWORDS_W);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        err_d      = err_q;
        rd_valid_d = rd_valid_q;
        arr_we     = 1'b0;
        arr_re     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MemRead || bus.MemWrite) begin
                    addr_d  = bus.Address;
                    wdata_d = bus.WriteData;
                    write_d = bus.MemWrite;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // The access happens on the edge that enters RESP.
                    arr_we     = write_q && in_range;
                    arr_re     = !write_q && in_range;
                    err_d      = !in_range;
                    rd_valid_d = !write_q && in_range;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= (state_d == RESP);
            busy_q     <= (state_d != IDLE);
        end
    end

    data_mem_array #(
        .NBITS  (NBITS),
        .NWORDS (NWORDS),
        .AW     (AW)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Writes and out-of-range accesses report zero; the value holds until the next response.
    assign bus.ReadData = rd_valid_q ? arr_rdata : '0;
    assign bus.Ready    = ready_q;
    assign bus.Busy     = busy_q;
    assign bus.Error    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a 48-word LATENCY=2 responder plus a LATENCY=1 instance for back-to-back timing.
module tb_data_mem_responder;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    data_mem_if #(.NBITS(8)) bus_a ();
    data_mem_if #(.NBITS(8)) bus_b ();

    data_mem_responder #(.NBITS(8), .NWORDS(48), .LATENCY(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    data_mem_responder #(.NBITS(8), .LATENCY(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Issues one request on bus_a and records what the responder did over 6 cycles.
    task automatic access(input logic wr, input logic rd, input logic [5:0] addr,
                          input logic [7:0] wd, input bit mutate,
                          output int rk, output int nready, output int nbusy,
                          output logic [7:0] rdat, output logic err,
                          output logic err_hold, output logic [7:0] rdat_hold);
        rk = 0; nready = 0; nbusy = 0;
        rdat = 8'hxx; err = 1'bx; err_hold = 1'bx; rdat_hold = 8'hxx;
        @(negedge clock);
        bus_a.MemWrite  = wr;
        bus_a.MemRead   = rd;
        bus_a.Address   = addr;
        bus_a.WriteData = wd;
        @(posedge clock);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (bus_a.Busy) nbusy++;
            if (rk != 0 && k == rk + 1) begin
                err_hold  = bus_a.Error;
                rdat_hold = bus_a.ReadData;
            end
            if (bus_a.Ready) begin
                nready++;
                if (rk == 0) begin
                    rk   = k;
                    rdat = bus_a.ReadData;
                    err  = bus_a.Error;
                    bus_a.MemRead  = 1'b0;
                    bus_a.MemWrite = 1'b0;
                end
            end
            if (k == 1 && mutate) begin
                bus_a.Address   = 6'd9;
                bus_a.MemWrite  = 1'b1;
                bus_a.WriteData = 8'h11;
            end
        end
        bus_a.MemRead  = 1'b0;
        bus_a.MemWrite = 1'b0;
        $display("access wr=%0b rd=%0b addr=%0d wd=%h: ready@%0d pulses=%0d busy=%0d rdata=%h err=%0b",
                 wr, rd, addr, wd, rk, nready, nbusy, rdat, err);
    endtask

    task automatic test_reset();
        n_checks++; if (bus_a.Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus_a.Ready); end
        n_checks++; if (bus_a.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_a.Busy); end
        n_checks++; if (bus_a.Error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", bus_a.Error); end
        n_checks++; if (bus_a.ReadData !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", bus_a.ReadData); end
        n_checks++; if (bus_b.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b expected 0", bus_b.Busy); end
        $display("reset: Ready=%b Busy=%b Error=%b ReadData=%h", bus_a.Ready, bus_a.Busy, bus_a.Error, bus_a.ReadData);
    endtask

    task automatic test_write_read();
        int rk, nr, nb; logic [7:0] rd, rdh; logic er, erh;
        access(1'b1, 1'b0, 6'd5, 8'hA5, 1'b0, rk, nr, nb, rd, er, erh, rdh);
        n_checks++; if (rk !== 3) begin n_fail++; $display("FAIL wr_ready_cycle: got %0d expected 3", rk); end
        n_checks++; if (nr !== 1) begin n_fail++; $display("FAIL wr_ready_pulses: got %0d expected 1", nr); end
        n_checks++; if (nb !== 3) begin n_fail++; $display("FAIL wr_busy_cycles: got %0d expected 3", nb); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_error: got %b expected 0", er); end
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL wr_rdata: got %h expected 00", rd); end
        access(1'b0, 1'b1, 6'd5, 8'h00, 1'b0, rk, nr, nb, rd, er, erh, rdh);
        n_checks++; if (rk !== 3) begin n_fail++; $display("FAIL rd_ready_cycle: got %0d expected 3", rk); end
        n_checks++; if (nr !== 1) begin n_fail++; $display("FAIL rd_ready_pulses: got %0d expected 1", nr); end
        n_checks++; if (nb !== 3) begin n_fail++; $display("FAIL rd_busy_cycles: got %0d expected 3", nb); end
        n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL rd_rdata: got %h expected a5", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_error: got %b expected 0", er); end
        n_checks++; if (rdh !== 8'hA5) begin n_fail++; $display("FAIL rd_rdata_hold: got %h expected a5", rdh); end
    endtask

    task automatic test_both_strobes();
        int rk, nr, nb; logic [7:0] rd, rdh; logic er, erh;
        access(1'b1, 1'b1, 6'd7, 8'h3C, 1'b0, rk, nr, nb, rd, er, erh, rdh);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL both_rdata: got %h expected 00", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL both_error: got %b expected 0", er); end
        access(1'b0, 1'b1, 6'd7, 8'h00, 1'b0, rk, nr, nb, rd, er, erh, rdh);
        n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL both_readback: got %h expected 3c", rd); end
    endtask

    task automatic test_out_of_range();
        int rk, nr, nb; logic [7:0] rd, rdh; logic er, erh;
        access(1'b1, 1'b0, 6'd50, 8'hFF, 1'b0, rk, nr, nb, rd, er, erh, rdh);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_wr_error: got %b expected 1", er); end
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oor_wr_rdata: got %h expected 00", rd); end
        n_checks++; if (erh !== 1'b1) begin n_fail++; $display("FAIL oor_error_hold: got %b expected 1", erh); end
        access(1'b0, 1'b1, 6'd50, 8'h00, 1'b0, rk, nr, nb, rd, er, erh, rdh);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_rd_error: got %b expected 1", er); end
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oor_rd_rdata: got %h expected 00", rd); end
        access(1'b0, 1'b1, 6'd47, 8'h00, 1'b0, rk, nr, nb, rd, er, erh, rdh);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL top_word_error: got %b expected 0", er); end
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL top_word_rdata: got %h expected 00", rd); end
    endtask

    task automatic test_inputs_ignored();
        int rk, nr, nb; logic [7:0] rd, rdh; logic er, erh;
        access(1'b0, 1'b1, 6'd5, 8'h00, 1'b1, rk, nr, nb, rd, er, erh, rdh);
        n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL ignore_rdata: got %h expected a5", rd); end
        access(1'b0, 1'b1, 6'd9, 8'h00, 1'b0, rk, nr, nb, rd, er, erh, rdh);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL ignore_word9: got %h expected 00", rd); end
    endtask

    task automatic test_reset_busy();
        int nr; int rk, nb; logic [7:0] rd, rdh; logic er, erh;
        nr = 0;
        @(negedge clock);
        bus_a.MemWrite = 1'b1; bus_a.Address = 6'd3; bus_a.WriteData = 8'h77;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus_a.MemWrite = 1'b0;
        n_checks++; if (bus_a.Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_busy: got %b expected 0", bus_a.Busy); end
        n_checks++; if (bus_a.Ready !== 1'b0) begin n_fail++; $display("FAIL rst_busy_ready: got %b expected 0", bus_a.Ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (bus_a.Ready) nr++;
        end
        n_checks++; if (nr !== 0) begin n_fail++; $display("FAIL rst_busy_no_ready: got %0d expected 0", nr); end
        $display("reset during busy: ready pulses afterwards=%0d", nr);
        access(1'b0, 1'b1, 6'd5, 8'h00, 1'b0, rk, nb, nb, rd, er, erh, rdh);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_clear_word5: got %h expected 00", rd); end
        access(1'b0, 1'b1, 6'd3, 8'h00, 1'b0, rk, nb, nb, rd, er, erh, rdh);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_clear_word3: got %h expected 00", rd); end
    endtask

    // LATENCY=1 with the request held: Ready in cycles 2,5,8,11, Busy in all but 3,6,9,12.
    task automatic test_back_to_back();
        @(negedge clock);
        bus_b.MemRead = 1'b1; bus_b.Address = 6'd2;
        @(posedge clock);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            $display("b2b cycle %0d: Ready=%b Busy=%b ReadData=%h", k, bus_b.Ready, bus_b.Busy, bus_b.ReadData);
            n_checks++;
            if (bus_b.Ready !== ((k % 3) == 2)) begin
                n_fail++; $display("FAIL b2b_ready_k%0d: got %b expected %b", k, bus_b.Ready, (k % 3) == 2);
            end
            n_checks++;
            if (bus_b.Busy !== ((k % 3) != 0)) begin
                n_fail++; $display("FAIL b2b_busy_k%0d: got %b expected %b", k, bus_b.Busy, (k % 3) != 0);
            end
        end
        bus_b.MemRead = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        bus_a.Address = '0; bus_a.WriteData = '0; bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0;
        bus_b.Address = '0; bus_b.WriteData = '0; bus_b.MemRead = 1'b0; bus_b.MemWrite = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_write_read();
        test_both_strobes();
        test_out_of_range();
        test_inputs_ignored();
        test_reset_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data memory that answers the datapath's load/store bus (`Address[NBITS-1:2]`, `WriteData`, `ReadData`) with a fixed, parameterised wait-state latency and a one-cycle `Ready` pulse. It sits on the memory side of the datapath and stands in for a cache or main memory. It captures one request, stalls for `LATENCY` cycles, commits the write or returns the read, and then becomes idle again.

## Interface
- `NBITS`, 8, data width; the word address is `NBITS-2` bits wide
- `NWORDS`, 2**(NBITS-2), number of implemented words; legal range 1..2**(NBITS-2)
- `LATENCY`, 2, edges from request capture to `Ready`; legal range 1..15
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `Address`  in  [NBITS-1:2]  word address of the request
- `WriteData`  in  NBITS  store data
- `MemRead`  in  1  load request
- `MemWrite`  in  1  store request
- `ReadData`  out  NBITS  load result; valid while `Ready`=1
- `Ready`  out  1  one-cycle response strobe
- `Error`  out  1  address ≥ NWORDS; valid while `Ready`=1
- `Busy`  out  1  request in progress; new requests are ignored

## Operation
- FSM states:
  - IDLE:
    - If `MemRead|MemWrite` is sampled at an edge, latch `Address`, `WriteData` and op, where op = write if `MemWrite`=1, else read.
    - Load `cnt = LATENCY-1` and go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - If `cnt==0`, go to RESP at the next edge, performing the access on that edge.
    - Otherwise decrement `cnt`.
  - RESP:
    - Go to IDLE unconditionally.
    - Requests sampled in RESP are ignored.
- Access, on the edge entering RESP:
  - In-range write: `mem[addr] <= wdata`; `ReadData <= 0`.
  - In-range read: `ReadData <= mem[addr]`.
  - Out of range (addr ≥ NWORDS): no array update; `ReadData <= 0`; `Error <= 1`.
  - `Error` is registered as 0 for every in-range access.
- `MemRead` and `MemWrite` both high: treated as a write.
- Only the latched request values are used. Input changes while in BUSY or RESP have no effect.
- `Ready`=1 exactly while in RESP. `Busy`=1 while in BUSY or RESP.
- `ReadData` and `Error` hold their values after RESP until the next response.
- Reset values:
  - State IDLE, `cnt` 0.
  - `Ready`, `Busy`, `Error` 0; `ReadData` 0.
  - All `mem` words cleared to 0.
- Reset mid-operation: the pending request is dropped, no `Ready` pulse is produced, and memory is cleared.

## Timing
- Request captured at edge E0.
- BUSY occupies cycles E0..E0+LATENCY.
- `Ready`, `ReadData` and `Error` are valid in the cycle between E0+LATENCY and E0+LATENCY+1.
- Back in IDLE after E0+LATENCY+1.
- Earliest next capture is E0+LATENCY+2, so throughput is one access per LATENCY+2 cycles.
- The requester keeps its request asserted until it observes `Ready`, and drops or changes it in the `Ready` cycle. A request still held after RESP is captured again as a new access.
- Counter width: $clog2(LATENCY+1).
- No combinational path from any input to any output.

## Structure
- Shared package `mem_pkg`:
  - `typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t`
  - `localparam MAX_LATENCY = 15`
- Sub-module `data_mem_array`:
  - NWORDS×NBITS storage with synchronous write and a registered read port.
  - Synchronous clear on `reset`.
  - Bound check (addr ≥ NWORDS) is computed in the parent.
- Parent module holds the FSM, the latency counter, the request latch and the output registers.

## Test plan
All scenarios use NBITS=8, NWORDS=48, LATENCY=2 unless stated otherwise.
- Write then read:
  - Stimulus: write 8'hA5 to word 5; then read word 5.
  - Required: each access gives a single `Ready` pulse at E0+2 with `Error`=0. The read returns `ReadData`=8'hA5. `Busy` is 1 for exactly 3 cycles per access.
- Both strobes high:
  - Stimulus: `MemRead`=`MemWrite`=1, word 7, 8'h3C.
  - Required: treated as a write; `ReadData`=0 at `Ready`. A subsequent read of word 7 returns 8'h3C.
- Out of range:
  - Stimulus: write 8'hFF to word 50, then read word 50, then read word 47.
  - Required: both accesses to word 50 give `Error`=1 and `ReadData`=0. The read of word 47 gives 8'h00 with `Error`=0.
- Inputs ignored while busy:
  - Stimulus: read word 5 (holding 8'hA5); in cycle E0+1 switch `Address` to 9 and assert `MemWrite` with 8'h11.
  - Required: response `ReadData`=8'hA5; word 9 is unchanged (reads 0).
- Reset during BUSY:
  - Stimulus: write 8'h77 to word 3; word 5 holds 8'hA5; pulse `reset` at E0+1.
  - Required: `Busy`=0 and `Ready`=0 after the reset edge, with no `Ready` pulse. Word 5 then reads 8'h00 and word 3 reads 8'h00.
- LATENCY=1 back-to-back:
  - Stimulus: request held continuously.
  - Required: `Ready` at E0+1; next capture at E0+3; `Ready` pulses every 3 cycles.
